// File: rtl/rr_arbiter16_ctrl.sv
// rr_arbiter16_ctrl
// Round-robin arbiter that shares one 16-input resource among 16 requesters.
// The arbiter keeps a grant until its owner drops the request. It then moves
// priority to the slot after the owner and re-arbitrates on the same edge, so
// no bubble cycle appears between owners. Outputs are registered.
//
// Optional build macro: ARB_TIMEOUT_EN
//   With the macro defined, an 8-bit hold counter revokes a grant after
//   TIMEOUT cycles. The revoked requester is then masked until it drops its
//   request. With the macro undefined, grants are held indefinitely and
//   timeout is always 0.
//
// Parameters:
//   PTR_INIT  round-robin pointer loaded at reset (0..15)
//   TIMEOUT   maximum grant hold in cycles (1..255), used only with ARB_TIMEOUT_EN
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req[15:0]   request lines, one per requester
//   gnt_valid   a grant is active
//   gnt_idx     encoded index of the granted requester
//   gnt_onehot  one-hot grant, all zero when idle
//   busy        FSM is in GRANT, equal to gnt_valid
//   timeout     one-cycle pulse when a grant is force-revoked
module rr_arbiter16_ctrl #(
  parameter int unsigned PTR_INIT = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt_onehot,
  output logic        busy,
  output logic        timeout
);

  if (PTR_INIT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("rr_arbiter16_ctrl: PTR_INIT or TIMEOUT out of range");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] onehot_q, onehot_d;
  logic        timeout_q, timeout_d;

  logic        owner_req;
  logic        release_gnt;
  logic        revoke;
  logic        rearb;
  logic [3:0]  search_ptr;
  logic [15:0] eligible;
  logic        found;
  logic [3:0]  winner;
  logic [3:0]  cand;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    timeout_d = 1'b0;
    owner_req = req[idx_q];
    revoke    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d  = cnt_q;
    // A masked requester is released from the mask once it drops its request.
    mask_d = mask_q & req;
    revoke = (state_q == GRANT) && owner_req && (cnt_q == HOLD_LAST);
`endif
    release_gnt = (state_q == GRANT) && !owner_req;
    rearb       = (state_q == IDLE) || release_gnt || revoke;

    // On release or revoke, the search starts at the slot after the owner.
    search_ptr = (state_q == GRANT) ? idx_q + 4'd1 : ptr_q;

    eligible = req;
`ifdef ARB_TIMEOUT_EN
    // Exclude the revoked owner now, because its mask bit only lands on this edge.
    eligible = req & ~mask_q & ~(revoke ? onehot_q : 16'h0000);
`endif

    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cand = search_ptr + 4'(i);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    if (rearb) begin
      if (state_q == GRANT) begin
        ptr_d = search_ptr;
      end
      if (found) begin
        state_d  = GRANT;
        idx_d    = winner;
        onehot_d = 16'd1 << winner;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end else begin
        state_d  = IDLE;
        idx_d    = '0;
        onehot_d = '0;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      cnt_d = cnt_q + 8'd1;
`endif
    end

`ifdef ARB_TIMEOUT_EN
    if (revoke) begin
      timeout_d = 1'b1;
      mask_d    = mask_d | onehot_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 4'(PTR_INIT);
      idx_q     <= '0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
`endif
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign busy       = (state_q == GRANT);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16_ctrl.sv
// Directed testbench for rr_arbiter16_ctrl. The stimulus drives one vector per
// cycle on the falling edge and queues the hand-computed outputs expected
// after the next rising edge. A separate monitor pops each entry and compares
// it against the outputs shortly after that rising edge.
module tb_rr_arbiter16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        busy;
  logic        timeout;

  typedef struct {
    string       name;
    logic        v;
    logic [3:0]  idx;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  rr_arbiter16_ctrl #(.PTR_INIT(0), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic r, input logic [15:0] rq,
                      input logic v, input logic [3:0] idx, input logic to);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    e.name = name;
    e.v    = v;
    e.idx  = idx;
    e.to   = to;
    exp_q.push_back(e);
  endtask

  // Monitor: compares all outputs one step after each rising edge.
  initial begin
    exp_t        e;
    logic [15:0] exp_oh;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_oh = e.v ? (16'd1 << e.idx) : 16'h0000;
        checks++;
        if (gnt_valid !== e.v || busy !== e.v || gnt_idx !== (e.v ? e.idx : 4'd0) ||
            gnt_onehot !== exp_oh || timeout !== e.to) begin
          errors++;
          $display("FAIL %s: got valid=%b busy=%b idx=%0d onehot=%h timeout=%b, want valid=%b busy=%b idx=%0d onehot=%h timeout=%b",
                   e.name, gnt_valid, busy, gnt_idx, gnt_onehot, timeout,
                   e.v, e.v, (e.v ? e.idx : 4'd0), exp_oh, e.to);
        end
      end
    end
  end

  initial begin
    // Reset and first grant
    step("reset0", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    step("reset1", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    step("reset2", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);
    step("first4", 1'b1, 16'h0010, 1'b1, 4'd4, 1'b0);
    step("hold4",  1'b1, 16'h0010, 1'b1, 4'd4, 1'b0);
    step("rel4",   1'b1, 16'h0000, 1'b0, 4'd0, 1'b0);
    step("rst_b",  1'b0, 16'h0000, 1'b0, 4'd0, 1'b0);

    // Fairness between 0 and 15, no bubble on handover
    step("fair_g0a", 1'b1, 16'h8001, 1'b1, 4'd0,  1'b0);
    step("fair_h0a", 1'b1, 16'h8001, 1'b1, 4'd0,  1'b0);
    step("fair_h0b", 1'b1, 16'h8001, 1'b1, 4'd0,  1'b0);
    step("fair_g15", 1'b1, 16'h8000, 1'b1, 4'd15, 1'b0);
    step("fair_h15", 1'b1, 16'h8001, 1'b1, 4'd15, 1'b0);
    step("fair_h15b",1'b1, 16'h8001, 1'b1, 4'd15, 1'b0);
    step("fair_g0b", 1'b1, 16'h0001, 1'b1, 4'd0,  1'b0);
    step("fair_h0c", 1'b1, 16'h8001, 1'b1, 4'd0,  1'b0);
    step("fair_h0d", 1'b1, 16'h8001, 1'b1, 4'd0,  1'b0);
    step("fair_g15b",1'b1, 16'h8000, 1'b1, 4'd15, 1'b0);
    step("fair_idle",1'b1, 16'h0000, 1'b0, 4'd0,  1'b0);

    // Pointer wrap from 15 to 0
    step("wrap_g15", 1'b1, 16'h8000, 1'b1, 4'd15, 1'b0);
    step("wrap_g1",  1'b1, 16'h0006, 1'b1, 4'd1,  1'b0);
    step("wrap_h1",  1'b1, 16'h0006, 1'b1, 4'd1,  1'b0);
    step("wrap_g2",  1'b1, 16'h0004, 1'b1, 4'd2,  1'b0);
    step("wrap_h2",  1'b1, 16'h0004, 1'b1, 4'd2,  1'b0);
    step("wrap_idle",1'b1, 16'h0000, 1'b0, 4'd0,  1'b0);

    // Search order from pointer 3, then wrapping past 15 to 0
    step("ord_g3",   1'b1, 16'h0009, 1'b1, 4'd3,  1'b0);
    step("ord_g0",   1'b1, 16'h0001, 1'b1, 4'd0,  1'b0);
    step("ord_idle", 1'b1, 16'h0000, 1'b0, 4'd0,  1'b0);

    // Mid-grant reset
    step("mid_g7",   1'b1, 16'h0080, 1'b1, 4'd7,  1'b0);
    step("mid_h7",   1'b1, 16'h0080, 1'b1, 4'd7,  1'b0);
    step("mid_rst",  1'b0, 16'h0080, 1'b0, 4'd0,  1'b0);
    step("mid_g0",   1'b1, 16'h0081, 1'b1, 4'd0,  1'b0);
    step("mid_h0",   1'b1, 16'h0081, 1'b1, 4'd0,  1'b0);

    // Long hold with req=0003
    step("to_rst",   1'b0, 16'h0000, 1'b0, 4'd0,  1'b0);
    step("to_g0",    1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0a",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0b",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0c",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
`ifdef ARB_TIMEOUT_EN
    step("to_revoke",1'b1, 16'h0003, 1'b1, 4'd1,  1'b1);
    step("to_h1a",   1'b1, 16'h0003, 1'b1, 4'd1,  1'b0);
    step("to_h1b",   1'b1, 16'h0003, 1'b1, 4'd1,  1'b0);
    step("to_h1c",   1'b1, 16'h0003, 1'b1, 4'd1,  1'b0);
    step("to_masked",1'b1, 16'h0001, 1'b0, 4'd0,  1'b0);
    step("to_drop0", 1'b1, 16'h0000, 1'b0, 4'd0,  1'b0);
    step("to_reg0",  1'b1, 16'h0001, 1'b1, 4'd0,  1'b0);
`else
    step("to_h0d",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0e",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0f",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0g",   1'b1, 16'h0003, 1'b1, 4'd0,  1'b0);
    step("to_h0h",   1'b1, 16'h0001, 1'b1, 4'd0,  1'b0);
    step("to_rel0",  1'b1, 16'h0000, 1'b0, 4'd0,  1'b0);
    step("to_reg0",  1'b1, 16'h0001, 1'b1, 4'd0,  1'b0);
`endif

    // Let the monitor drain the queue, with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
